// File: rtl/fe_capture_packer.sv
// fe_capture_packer: turns the sniffed USB byte/status stream into timestamped sniff-FIFO
// commands (DATA/STAT/TIME). Define FE_CAPTURE_STAT_EN to emit STAT entries on I_usb_stat changes.
module fe_capture_packer #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pQUEUE_DEPTH           = 4
) (
    input  logic                             fe_clk,
    input  logic                             reset_n,
    input  logic                             I_arm,
    input  logic                             I_timestamps_disable,
    input  logic [15:0]                      I_capture_len,
    input  logic                             I_fifo_full,
    input  logic [7:0]                       I_rx_data,
    input  logic                             I_rx_valid,
    input  logic [4:0]                       I_usb_stat,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_capture_time,
    output logic [7:0]                       O_capture_data,
    output logic [4:0]                       O_capture_stat,
    output logic [1:0]                       O_capture_cmd,
    output logic                             O_capture_data_wr,
    output logic                             O_capturing,
    output logic                             O_capture_done,
    output logic                             O_queue_overflow
);

    localparam int FW = pTIMESTAMP_FULL_WIDTH;
    localparam int AW = $clog2(pQUEUE_DEPTH);

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

    localparam logic [FW-1:0] SHORT_MAX = FW'((64'd1 << pTIMESTAMP_SHORT_WIDTH) - 64'd1);
    localparam logic [AW:0]   DEPTH     = (AW+1)'(pQUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [7:0]    data;
        logic [4:0]    stat;
        logic [FW-1:0] delta;
    } entry_t;

    state_t        state, state_nxt;
    logic          arm_prev;
    logic [FW-1:0] ts_cnt;
    logic [15:0]   data_cnt;
    logic          overflow;
    logic          split_pend;

    entry_t        mem [pQUEUE_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, data_idx;
    logic [AW:0]   count, free, n_push;

    logic          arm_rise, capture_start;
    logic          data_evt, stat_evt, data_push, stat_push, drop;
    entry_t        data_entry, first_in, head;
    logic          head_valid, is_short, drain_en, emit_time, pop, len_hit;

`ifdef FE_CAPTURE_STAT_EN
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
    logic [4:0] stat_prev;
    entry_t     stat_entry;

    always_ff @(posedge fe_clk) begin
        if (!reset_n) stat_prev <= '0;
        else          stat_prev <= I_usb_stat;
    end
`endif

    always_comb begin
        arm_rise      = I_arm && !arm_prev;
        capture_start = (state == S_IDLE) && arm_rise;

        data_evt = (state == S_CAPTURE) && I_rx_valid;
`ifdef FE_CAPTURE_STAT_EN
        stat_evt   = (state == S_CAPTURE) && (I_usb_stat != stat_prev);
        stat_entry = '{cmd: FE_FIFO_CMD_STAT, data: 8'h00, stat: I_usb_stat, delta: ts_cnt};
`else
        stat_evt = 1'b0;
`endif
        data_entry = '{cmd: FE_FIFO_CMD_DATA, data: I_rx_data, stat: I_usb_stat, delta: ts_cnt};

        // STAT takes the first free slot; DATA needs one more beyond it.
        free      = DEPTH - count;
        stat_push = stat_evt && (free != '0);
        data_push = data_evt && (free > (AW+1)'(stat_push));
        drop      = (stat_evt && !stat_push) || (data_evt && !data_push);
        n_push    = (AW+1)'(stat_push) + (AW+1)'(data_push);
        data_idx  = wr_ptr + AW'(stat_push);

        first_in = data_entry;
`ifdef FE_CAPTURE_STAT_EN
        if (stat_push) first_in = stat_entry;
`endif

        // An empty queue forwards this cycle's incoming entry so the write lands one cycle later.
        head_valid = (count != '0) || stat_push || data_push;
        head       = (count != '0) ? mem[rd_ptr] : first_in;

        drain_en  = ((state == S_CAPTURE) || (state == S_DRAIN)) && head_valid && !I_fifo_full;
        is_short  = I_timestamps_disable || (head.delta <= SHORT_MAX);
        emit_time = drain_en && !split_pend && !is_short;
        pop       = drain_en && !emit_time;

        len_hit = (I_capture_len != 16'd0) && data_push && ((data_cnt + 16'd1) == I_capture_len);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm_rise) state_nxt = S_CAPTURE;
            S_CAPTURE: if (len_hit) state_nxt = S_DRAIN;
            S_DRAIN:   if ((count == '0) && !split_pend) state_nxt = S_DONE;
            S_DONE:    if (!I_arm) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            arm_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            arm_prev <= I_arm;
        end
    end

    always_ff @(posedge fe_clk) begin
`ifdef FE_CAPTURE_STAT_EN
        if (stat_push) mem[wr_ptr] <= stat_entry;
`endif
        if (data_push) mem[data_idx] <= data_entry;
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_n || capture_start) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            split_pend <= 1'b0;
            ts_cnt     <= '0;
            data_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(n_push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + n_push - (AW+1)'(pop);
            data_cnt <= data_cnt + 16'(data_push);
            if (drop) overflow <= 1'b1;

            if (emit_time)  split_pend <= 1'b1;
            else if (pop)   split_pend <= 1'b0;

            if (stat_evt || data_evt) ts_cnt <= FW'(1);
            else if (ts_cnt != '1)    ts_cnt <= ts_cnt + FW'(1);
        end
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            O_capture_time    <= '0;
            O_capture_data    <= '0;
            O_capture_stat    <= '0;
            O_capture_cmd     <= '0;
            O_capture_data_wr <= 1'b0;
        end else begin
            O_capture_data_wr <= drain_en;
            if (emit_time) begin
                O_capture_cmd  <= FE_FIFO_CMD_TIME;
                O_capture_time <= head.delta;
            end else if (pop) begin
                O_capture_cmd  <= head.cmd;
                O_capture_time <= (split_pend || I_timestamps_disable) ? '0 : head.delta;
                O_capture_data <= head.data;
                O_capture_stat <= head.stat;
            end
        end
    end

    assign O_capturing      = (state == S_CAPTURE) || (state == S_DRAIN);
    assign O_capture_done   = (state == S_DONE);
    assign O_queue_overflow = overflow;

endmodule

// File: doc/fe_capture_packer.md
Name: fe_capture_packer

Overview:
- Write-side producer for the sniff FIFO, in the fe_clk domain. Turns the front-end's sniffed USB byte/status stream into timestamped FIFO commands (DATA/STAT/TIME).
- Drives the register block's I_fe_capture_* inputs and honours its O_arm, O_capture_len, O_timestamps_disable and O_fifo_full outputs.
- Contains a small event queue, so back-to-back bytes after a long idle gap survive the extra TIME entry and short FIFO-full stalls.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16, width of the delta counter and of TIME entries.
- pTIMESTAMP_SHORT_WIDTH, 3, delta width carried inside DATA/STAT entries.
- pQUEUE_DEPTH, 4, event queue entries; power of 2, at least 2.

Ports:
- fe_clk  in  1  front-end clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- I_arm  in  1  from register block; a rising edge starts a capture.
- I_timestamps_disable  in  1  forces all time fields to 0 and suppresses TIME entries.
- I_capture_len  in  16  number of DATA entries to capture; 0 = unlimited.
- I_fifo_full  in  1  sniff FIFO full; stalls the drain.
- I_rx_data  in  8  sniffed byte.
- I_rx_valid  in  1  I_rx_data is valid this cycle.
- I_usb_stat  in  5  live line/PHY status bits.
- O_capture_time  out  pTIMESTAMP_FULL_WIDTH  delta for the entry.
- O_capture_data  out  8  byte (DATA entries).
- O_capture_stat  out  5  status snapshot.
- O_capture_cmd  out  2  FE_FIFO_CMD_DATA / _STAT / _TIME (defines.v encodings).
- O_capture_data_wr  out  1  one-cycle write strobe.
- O_capturing  out  1  high in CAPTURE and DRAIN.
- O_capture_done  out  1  high in DONE.
- O_queue_overflow  out  1  sticky; an event was dropped because the queue was full.

Behaviour:
- Reset (reset_n low at an fe_clk edge): state IDLE; all outputs 0; queue emptied; counters 0. Reset applied mid-capture aborts it immediately.
- States:
  - IDLE -> CAPTURE when I_arm is 1 and was 0 on the previous cycle.
  - CAPTURE -> DRAIN on the cycle the I_capture_len-th DATA event is enqueued (only when I_capture_len != 0).
  - DRAIN -> DONE when the queue is empty and no TIME/event split is pending.
  - DONE -> IDLE when I_arm = 0.
  - An I_arm fall during CAPTURE is ignored, because the register block clears arm on a pattern match.
  - Entering CAPTURE clears the queue, the delta counter, the DATA count and O_queue_overflow.
- Event sources, CAPTURE state only:
  - DATA event: I_rx_valid = 1.
  - STAT event: I_usb_stat differs from its value on the previous cycle (see optional feature).
  - Both on the same cycle: the STAT event is enqueued first, then DATA, taking 2 slots.
- Delta counter (ts_cnt):
  - Increments every cycle, saturating at all-ones.
  - On an event cycle, the event's delta = ts_cnt and ts_cnt <= 1. An event on the first CAPTURE cycle therefore has delta 0; back-to-back events have delta 1.
- Each queue entry holds {cmd, data, stat, delta}.
- Enqueue when the queue is not full; otherwise drop the event and set O_queue_overflow. A dropped DATA event does not increment the DATA count.
- Drain: at most one write per cycle, registered; nothing drains while I_fifo_full = 1.
  - Entry at head with delta <= 2^pTIMESTAMP_SHORT_WIDTH-1, or I_timestamps_disable = 1: emit it with O_capture_time = delta (0 when disabled); pop.
  - Otherwise: emit TIME with O_capture_time = delta (full width); on the next non-stalled cycle emit the entry with time 0; pop.
  - O_capture_data = 0 for STAT entries. For TIME entries the data and stat outputs hold their previous values.
- Latency: an event at cycle N with the queue empty and no stall gives O_capture_data_wr at N+1 (short delta) or TIME at N+1 and the entry at N+2.
- Drained entries from the previous capture are never emitted after re-arm, because the queue is cleared on entering CAPTURE.

Optional Feature:
- FE_CAPTURE_STAT_EN defined: I_usb_stat changes generate STAT entries as described above.
- Not defined: no STAT events are generated; the status is carried only in the O_capture_stat field of DATA entries, and the queue never takes two slots in one cycle.

Test Plan:
- Arm; bytes 0x11, 0x22 on consecutive cycles starting 3 cycles after arm -> DATA 0x11 time 3, DATA 0x22 time 1; no TIME entries.
- Arm; byte 0xA5 at 100 cycles after arm, then 0x5A on the next cycle -> TIME 100, DATA 0xA5 time 0, DATA 0x5A time 1, written on 3 consecutive cycles.
- I_capture_len = 2; 5 bytes offered -> exactly 2 DATA entries; O_capture_done = 1 after the drain; bytes 3-5 ignored.
- I_fifo_full held 6 cycles during a 6-byte burst, pQUEUE_DEPTH = 4 -> first 4 bytes emitted after the release; O_queue_overflow = 1.
- FE_CAPTURE_STAT_EN defined; I_usb_stat 0x00 -> 0x04 with a byte on the same cycle -> STAT (stat 0x04) then DATA; without the macro -> DATA only, stat field 0x04.
- reset_n low mid-burst -> O_capture_data_wr = 0 and state IDLE next cycle; re-arm -> no stale entries emitted.
